// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the registered N-channel selector.
//   ARB_FIXED / ARB_RR : arbitration mode encodings for the MODE parameter
//   out_state_t        : output register state (EMPTY / FULL)
//   clog2()            : select/index field width for a channel count
package mux_pkg;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational request picker.
//   req     in  N     request vector
//   ptr     in  SELW  first index to scan (round robin only; ignored in fixed mode)
//   gnt     out N     one-hot grant, zero when no request
//   gnt_idx out SELW  index of the granted request
//   any     out 1     at least one request present
module rr_pick
    import mux_pkg::*;
#(
    parameter  int unsigned N    = 4,
    parameter  int unsigned MODE = ARB_RR,
    localparam int unsigned SELW = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    logic [SELW-1:0]  start;
    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;

    // Fixed priority is round robin with the scan always starting at 0.
    assign start = (MODE == ARB_RR) ? ptr : '0;

    // Doubling the vector lets a plain right shift act as a rotate:
    // rot[j] corresponds to req[(start + j) mod N].
    assign dbl = {req, req};
    assign rot = N'(dbl >> start);

    always_comb begin
        int unsigned pos;
        any     = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        pos     = 0;
        for (int unsigned j = 0; j < N; j++) begin
            if (!any && rot[j]) begin
                any = 1'b1;
                pos = 32'(start) + j;
                if (pos >= N) begin
                    pos = pos - N;
                end
                gnt_idx = SELW'(pos);
            end
        end
        if (any) begin
            gnt = N'(1) << gnt_idx;
        end
    end

endmodule

// File: rtl/mux_arb_reg.sv
// mux_arb_reg: registered N-channel WIDTH-bit selector with valid/ready
// handshakes, fixed-priority or round-robin arbitration and a forced select.
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   in_data    N*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid   N        channel i offers data
//   in_ready   N        one-hot (or zero) acceptance of a channel this cycle
//   force_en   1        use force_sel instead of arbitration
//   force_sel  SELW     forced channel index
//   out_data   WIDTH    registered selected data
//   out_sel    SELW     channel that produced out_data
//   out_valid  1        output register holds data
//   out_ready  1        consumer accepts out_data
module mux_arb_reg
    import mux_pkg::*;
#(
    parameter  int unsigned WIDTH = 5,
    parameter  int unsigned N     = 4,
    parameter  int unsigned MODE  = ARB_RR,
    localparam int unsigned SELW  = clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 force_en,
    input  logic [SELW-1:0]      force_sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int unsigned NPAD = 1 << SELW;

    out_state_t       state_q;
    out_state_t       state_d;
    logic [SELW-1:0]  ptr_q;
    logic [WIDTH-1:0] data_q;
    logic [SELW-1:0]  sel_q;

    logic             can_load;
    logic [NPAD-1:0]  valid_pad;
    logic             force_hit;
    logic [N-1:0]     pick_gnt;
    logic [SELW-1:0]  pick_idx;
    logic             pick_any;
    logic             gnt_any;
    logic [SELW-1:0]  gnt_idx;

    rr_pick #(
        .N    (N),
        .MODE (MODE)
    ) u_pick (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign can_load  = !out_valid || out_ready;

    // Zero-padding to the full select range makes an out-of-range
    // force_sel read a 0 valid bit, so it can never produce a grant.
    assign valid_pad = NPAD'(in_valid);
    assign force_hit = valid_pad[force_sel];

    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        in_ready = '0;
        if (can_load) begin
            if (force_en) begin
                if (force_hit) begin
                    gnt_any  = 1'b1;
                    gnt_idx  = force_sel;
                    in_ready = N'(1) << force_sel;
                end
            end else begin
                gnt_any  = pick_any;
                gnt_idx  = pick_idx;
                in_ready = pick_gnt;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (gnt_any) state_d = ST_FULL;
            ST_FULL: begin
                if (gnt_any) begin
                    state_d = ST_FULL;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Data and select only change on a grant; a plain drain keeps them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            sel_q  <= '0;
            ptr_q  <= '0;
        end else if (gnt_any) begin
            data_q <= in_data[gnt_idx*WIDTH +: WIDTH];
            sel_q  <= gnt_idx;
            if (MODE == ARB_RR && !force_en) begin
                ptr_q <= (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_arb_reg.sv
// tb_mux_arb_reg: directed bench for mux_arb_reg with three instances
// (N=4 round robin, N=5 fixed priority, N=2 round robin) and a per-instance
// scoreboard of {sel, data} items expected in the output register.
module tb_mux_arb_reg;

    logic clk = 1'b0;
    logic rst;

    logic [19:0] a_data;
    logic [3:0]  a_valid, a_ready;
    logic        a_fen;
    logic [1:0]  a_fsel;
    logic [4:0]  a_odata;
    logic [1:0]  a_osel;
    logic        a_ovalid, a_oready;

    logic [24:0] b_data;
    logic [4:0]  b_valid, b_ready;
    logic        b_fen;
    logic [2:0]  b_fsel;
    logic [4:0]  b_odata;
    logic [2:0]  b_osel;
    logic        b_ovalid, b_oready;

    logic [9:0]  c_data;
    logic [1:0]  c_valid, c_ready;
    logic        c_fen;
    logic [0:0]  c_fsel;
    logic [4:0]  c_odata;
    logic [0:0]  c_osel;
    logic        c_ovalid, c_oready;

    int checks   = 0;
    int failures = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] qc[$];

    always #5 clk = ~clk;

    mux_arb_reg #(.WIDTH(5), .N(4), .MODE(1)) u_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .force_en(a_fen), .force_sel(a_fsel), .out_data(a_odata), .out_sel(a_osel),
        .out_valid(a_ovalid), .out_ready(a_oready)
    );

    mux_arb_reg #(.WIDTH(5), .N(5), .MODE(0)) u_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .force_en(b_fen), .force_sel(b_fsel), .out_data(b_odata), .out_sel(b_osel),
        .out_valid(b_ovalid), .out_ready(b_oready)
    );

    mux_arb_reg #(.WIDTH(5), .N(2), .MODE(1)) u_c (
        .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
        .force_en(c_fen), .force_sel(c_fsel), .out_data(c_odata), .out_sel(c_osel),
        .out_valid(c_ovalid), .out_ready(c_oready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle on instance d: check in_ready, pop/compare the item the
    // consumer takes at this edge, push the item expected to load at this edge.
    task automatic cyc(input int d, input logic [15:0] exp_rdy, input int exp_g,
                       input logic [4:0] exp_dat);
        logic [15:0] rdy;
        logic        ov, ordy;
        logic [31:0] obs, e;
        #1;
        rdy = '0; ov = 1'b0; ordy = 1'b0; obs = '0;
        case (d)
            0: begin rdy = 16'(a_ready); ov = a_ovalid; ordy = a_oready; obs = {25'd0, a_osel, a_odata}; end
            1: begin rdy = 16'(b_ready); ov = b_ovalid; ordy = b_oready; obs = {24'd0, b_osel, b_odata}; end
            default: begin rdy = 16'(c_ready); ov = c_ovalid; ordy = c_oready; obs = {26'd0, c_osel, c_odata}; end
        endcase
        chk($sformatf("dut%0d_in_ready", d), 32'(rdy), 32'(exp_rdy));
        if (ov && ordy) begin
            e = '1;
            case (d)
                0: if (qa.size() > 0) e = qa.pop_front();
                1: if (qb.size() > 0) e = qb.pop_front();
                default: if (qc.size() > 0) e = qc.pop_front();
            endcase
            chk($sformatf("dut%0d_out_item", d), obs, e);
        end
        if (exp_g >= 0) begin
            e = (32'(exp_g) << 5) | 32'(exp_dat);
            case (d)
                0: qa.push_back(e);
                1: qb.push_back(e);
                default: qc.push_back(e);
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_data = '0; a_valid = '0; a_fen = 1'b0; a_fsel = '0; a_oready = 1'b0;
        b_data = '0; b_valid = '0; b_fen = 1'b0; b_fsel = '0; b_oready = 1'b0;
        c_data = '0; c_valid = '0; c_fen = 1'b0; c_fsel = '0; c_oready = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_a_ovalid", 32'(a_ovalid), 32'd0);
        chk("rst_a_odata",  32'(a_odata),  32'd0);
        chk("rst_a_osel",   32'(a_osel),   32'd0);
        chk("rst_a_ready",  32'(a_ready),  32'd0);
        chk("rst_b_ovalid", 32'(b_ovalid), 32'd0);
        chk("rst_c_ovalid", 32'(c_ovalid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset mid-stream: load 1A from ch2 (ptr -> 3), then async reset
        a_data  = {5'h04, 5'h1A, 5'h02, 5'h01};
        a_valid = 4'b0100;
        cyc(0, 16'h4, 2, 5'h1A);
        a_valid = '0;
        #2;
        chk("pre_rst_ovalid", 32'(a_ovalid), 32'd1);
        chk("pre_rst_odata",  32'(a_odata),  32'h1A);
        chk("pre_rst_osel",   32'(a_osel),   32'd2);
        rst = 1'b1;
        #1;
        chk("async_rst_ovalid", 32'(a_ovalid), 32'd0);
        chk("async_rst_odata",  32'(a_odata),  32'd0);
        chk("async_rst_osel",   32'(a_osel),   32'd0);
        qa.delete(); qb.delete(); qc.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round robin, all valid: first grant ch0, then 1,2,3,0
        a_data   = {5'h04, 5'h03, 5'h02, 5'h01};
        a_valid  = 4'b1111;
        a_oready = 1'b1;
        cyc(0, 16'h1, 0, 5'h01);
        cyc(0, 16'h2, 1, 5'h02);
        cyc(0, 16'h4, 2, 5'h03);
        cyc(0, 16'h8, 3, 5'h04);
        cyc(0, 16'h1, 0, 5'h01);

        // Backpressure: ch1 carries 07, hold out_ready low for 5 cycles
        a_data = {5'h04, 5'h03, 5'h07, 5'h01};
        cyc(0, 16'h2, 1, 5'h07);
        a_oready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 16'h0, -1, 5'h00);
            chk("stall_odata",  32'(a_odata),  32'h07);
            chk("stall_ovalid", 32'(a_ovalid), 32'd1);
        end
        a_oready = 1'b1;
        cyc(0, 16'h4, 2, 5'h03);
        chk("no_bubble_ovalid", 32'(a_ovalid), 32'd1);
        chk("no_bubble_odata",  32'(a_odata),  32'h03);

        // Force ch2 twice with ptr at 0; ptr must still be 0 afterwards
        cyc(0, 16'h8, 3, 5'h04);
        a_fen  = 1'b1;
        a_fsel = 2'd2;
        cyc(0, 16'h4, 2, 5'h03);
        cyc(0, 16'h4, 2, 5'h03);
        a_fen = 1'b0;
        cyc(0, 16'h1, 0, 5'h01);
        // Forced channel not valid: no grant, register drains
        a_fen   = 1'b1;
        a_valid = 4'b1011;
        cyc(0, 16'h0, -1, 5'h00);
        chk("force_invalid_ovalid", 32'(a_ovalid), 32'd0);
        cyc(0, 16'h0, -1, 5'h00);
        chk("force_invalid_ovalid2", 32'(a_ovalid), 32'd0);
        a_fen   = 1'b0;
        a_valid = '0;

        // Fixed priority (N=5): ch1 beats ch3 until ch1 drops
        b_data   = {5'h14, 5'h13, 5'h12, 5'h11, 5'h10};
        b_valid  = 5'b01010;
        b_oready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 16'h2, 1, 5'h11);
        end
        b_valid = 5'b01000;
        cyc(1, 16'h8, 3, 5'h13);
        b_valid = '0;
        cyc(1, 16'h0, -1, 5'h00);
        chk("fp_drain_ovalid", 32'(b_ovalid), 32'd0);

        // Out-of-range force_sel (5 and 7 with N=5): never granted
        b_fen   = 1'b1;
        b_fsel  = 3'd5;
        b_valid = 5'b11111;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 16'h0, -1, 5'h00);
            chk("force_oob5_ovalid", 32'(b_ovalid), 32'd0);
        end
        b_fsel = 3'd7;
        cyc(1, 16'h0, -1, 5'h00);
        chk("force_oob7_ovalid", 32'(b_ovalid), 32'd0);
        b_fsel = 3'd4;
        cyc(1, 16'h10, 4, 5'h14);
        b_fen   = 1'b0;
        b_valid = '0;
        cyc(1, 16'h0, -1, 5'h00);

        // N=2 legacy 2:1 behaviour: forced select toggles A/B
        c_data   = {5'h13, 5'h0C};
        c_valid  = 2'b11;
        c_oready = 1'b1;
        c_fen    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c_fsel = 1'(i % 2);
            if (i % 2 == 1) cyc(2, 16'h2, 1, 5'h13);
            else            cyc(2, 16'h1, 0, 5'h0C);
        end
        // Round robin: ptr 0 -> 1, then ptr 1 with only ch0 valid wraps back to 1
        c_fen   = 1'b0;
        c_valid = 2'b01;
        cyc(2, 16'h1, 0, 5'h0C);
        cyc(2, 16'h1, 0, 5'h0C);
        c_valid = 2'b11;
        cyc(2, 16'h2, 1, 5'h13);
        c_valid = '0;
        cyc(2, 16'h0, -1, 5'h00);
        chk("n2_drain_ovalid", 32'(c_ovalid), 32'd0);

        chk("sb_a_empty", 32'(qa.size()), 32'd0);
        chk("sb_b_empty", 32'(qb.size()), 32'd0);
        chk("sb_c_empty", 32'(qc.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
